// File: rtl/pif_ram_arbiter.sv
// Purpose: arbitrates a serial-side port (A, with 16-beat bursts) and a CPU port (B) onto one single-port RAM.
// Latency: request sampled at cycle N, RAM access and grant registered at N+1, read data with rvalid at N+2.
// Backpressure: a requester is masked in its own grant cycle; B is locked out while an A burst is in progress.
// Optional feature: define PIF_RAM_ARB_BURST_TIMEOUT_EN to abort a stalled burst after 64 idle cycles (sets burst_err).
module pif_ram_arbiter (
    input  logic        clk,
    input  logic        reset,
    // serial side (A)
    input  logic        a_req,
    input  logic        a_wren,
    input  logic        a_burst,
    input  logic [8:0]  a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    // CPU side (B)
    input  logic        b_req,
    input  logic        b_wren,
    input  logic [8:0]  b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_be,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    // single-port RAM, one-cycle read latency
    output logic [8:0]  ram_addr,
    output logic        ram_wren,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    // status
    output logic        burst_active,
    output logic        burst_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_A   = 2'd1,
        GNT_B   = 2'd2,
        BURST_A = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_a_q, last_a_d;          // 1: A won the last contest, 0: B (reset value)
    logic        a_gnt_q, a_gnt_d;
    logic        b_gnt_q, b_gnt_d;
    logic [8:0]  ram_addr_q, ram_addr_d;
    logic        ram_wren_q, ram_wren_d;
    logic [3:0]  ram_be_q, ram_be_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        a_rvalid_q, a_rvalid_d;
    logic        b_rvalid_q, b_rvalid_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;
    logic [8:0]  base_q, base_d;
    logic [3:0]  beat_q, beat_d;
    logic        burst_wren_q, burst_wren_d;
    logic        burst_active_q, burst_active_d;

`ifdef PIF_RAM_ARB_BURST_TIMEOUT_EN
    logic [5:0]  idle_cnt_q, idle_cnt_d;
    logic        burst_err_q, burst_err_d;
`endif

    logic a_ok;
    logic b_ok;
    logic burst_last;

    // A requester that holds a grant this cycle sits out the contest
    assign a_ok = a_req & ~a_gnt_q;
    assign b_ok = b_req & ~b_gnt_q;

    // Arbitration, burst sequencing and next-state for the RAM command registers
    always_comb begin
        state_d      = IDLE;
        last_a_d     = last_a_q;
        a_gnt_d      = 1'b0;
        b_gnt_d      = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wren_d   = 1'b0;
        ram_be_d     = 4'h0;
        ram_wdata_d  = ram_wdata_q;
        base_d       = base_q;
        beat_d       = beat_q;
        burst_wren_d = burst_wren_q;
        burst_last   = 1'b0;
`ifdef PIF_RAM_ARB_BURST_TIMEOUT_EN
        idle_cnt_d   = idle_cnt_q;
        burst_err_d  = burst_err_q;
`endif

        case (state_q)
            BURST_A: begin
                state_d = BURST_A;
                if (a_ok) begin
                    a_gnt_d     = 1'b1;
                    ram_addr_d  = base_q + {5'd0, beat_q};
                    ram_wren_d  = burst_wren_q;
                    ram_be_d    = 4'hF;
                    ram_wdata_d = a_wdata;
                    beat_d      = beat_q + 4'd1;
`ifdef PIF_RAM_ARB_BURST_TIMEOUT_EN
                    idle_cnt_d  = 6'd0;
`endif
                    if (beat_q == 4'd15) begin
                        // final beat: hand the next contest to B
                        burst_last = 1'b1;
                        state_d    = GNT_A;
                        last_a_d   = 1'b1;
                        beat_d     = 4'd0;
                    end
                end
`ifdef PIF_RAM_ARB_BURST_TIMEOUT_EN
                else if (idle_cnt_q == 6'd63) begin
                    // 64th consecutive cycle without a beat: give up on the burst
                    state_d     = IDLE;
                    beat_d      = 4'd0;
                    idle_cnt_d  = 6'd0;
                    burst_err_d = 1'b1;
                    last_a_d    = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 6'd1;
                end
`endif
            end
            default: begin
                // IDLE, GNT_A, GNT_B: round-robin contest between eligible requesters
                if (a_ok && (!b_ok || !last_a_q)) begin
                    a_gnt_d     = 1'b1;
                    last_a_d    = 1'b1;
                    ram_addr_d  = a_addr;
                    ram_wren_d  = a_wren;
                    ram_be_d    = 4'hF;
                    ram_wdata_d = a_wdata;
                    if (a_burst) begin
                        state_d      = BURST_A;
                        base_d       = a_addr;
                        beat_d       = 4'd1;
                        burst_wren_d = a_wren;
`ifdef PIF_RAM_ARB_BURST_TIMEOUT_EN
                        idle_cnt_d   = 6'd0;
`endif
                    end else begin
                        state_d = GNT_A;
                    end
                end else if (b_ok) begin
                    state_d     = GNT_B;
                    b_gnt_d     = 1'b1;
                    last_a_d    = 1'b0;
                    ram_addr_d  = b_addr;
                    ram_wren_d  = b_wren;
                    ram_be_d    = b_be;
                    ram_wdata_d = b_wdata;
                end
            end
        endcase

        burst_active_d = (state_d == BURST_A) | burst_last;
    end

    // Read return: rvalid one cycle after a read command, rdata holds between pulses
    always_comb begin
        a_rvalid_d = a_gnt_q & ~ram_wren_q;
        b_rvalid_d = b_gnt_q & ~ram_wren_q;
        a_rdata_d  = a_rvalid_q ? ram_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_q ? ram_rdata : b_rdata_q;
    end

    // State and command registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_a_q       <= 1'b0;
            a_gnt_q        <= 1'b0;
            b_gnt_q        <= 1'b0;
            ram_addr_q     <= 9'd0;
            ram_wren_q     <= 1'b0;
            ram_be_q       <= 4'h0;
            ram_wdata_q    <= 32'd0;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            a_rdata_q      <= 32'd0;
            b_rdata_q      <= 32'd0;
            base_q         <= 9'd0;
            beat_q         <= 4'd0;
            burst_wren_q   <= 1'b0;
            burst_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_a_q       <= last_a_d;
            a_gnt_q        <= a_gnt_d;
            b_gnt_q        <= b_gnt_d;
            ram_addr_q     <= ram_addr_d;
            ram_wren_q     <= ram_wren_d;
            ram_be_q       <= ram_be_d;
            ram_wdata_q    <= ram_wdata_d;
            a_rvalid_q     <= a_rvalid_d;
            b_rvalid_q     <= b_rvalid_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
            base_q         <= base_d;
            beat_q         <= beat_d;
            burst_wren_q   <= burst_wren_d;
            burst_active_q <= burst_active_d;
        end
    end

`ifdef PIF_RAM_ARB_BURST_TIMEOUT_EN
    // Burst stall watchdog; burst_err stays set until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q  <= 6'd0;
            burst_err_q <= 1'b0;
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            burst_err_q <= burst_err_d;
        end
    end
    assign burst_err = burst_err_q;
`else
    assign burst_err = 1'b0;
`endif

    assign a_gnt        = a_gnt_q;
    assign b_gnt        = b_gnt_q;
    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign a_rdata      = a_rdata_d;
    assign b_rdata      = b_rdata_d;
    assign ram_addr     = ram_addr_q;
    assign ram_wren     = ram_wren_q;
    assign ram_be       = ram_be_q;
    assign ram_wdata    = ram_wdata_q;
    assign burst_active = burst_active_q;

endmodule

// File: tb/tb_pif_ram_arbiter.sv
// Bench for pif_ram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Includes a behavioural single-port RAM with one-cycle read latency.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven at the same point.
module tb_pif_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_wren = 1'b0, a_burst = 1'b0;
    logic [8:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        a_gnt, a_rvalid;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0, b_wren = 1'b0;
    logic [8:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_be = '0;
    logic        b_gnt, b_rvalid;
    logic [31:0] b_rdata;
    logic [8:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        burst_active, burst_err;

    int checks = 0;
    int errors = 0;

    pif_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wren(a_wren), .a_burst(a_burst), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_wren(b_wren), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_be(ram_be), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .burst_active(burst_active), .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    // RAM model: reset fills a known pattern, byte-enabled writes, registered read
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i) * 32'h9E3779B1;
        end else if (ram_wren) begin
            for (int k = 0; k < 4; k++)
                if (ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_req = 0; a_wren = 0; a_burst = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_wren = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0) begin errors++; $display("FAIL reset_gnt_rvalid: got %b expected 0000", {a_gnt, b_gnt, a_rvalid, b_rvalid}); end
        checks++; if ({ram_wren, ram_be} !== 5'b0) begin errors++; $display("FAIL reset_wren_be: got %b expected 00000", {ram_wren, ram_be}); end
        checks++; if (ram_addr !== 9'd0 || ram_wdata !== 32'd0) begin errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 000/00000000", ram_addr, ram_wdata); end
        checks++; if (a_rdata !== 32'd0 || b_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", a_rdata, b_rdata); end
        checks++; if ({burst_active, burst_err} !== 2'b00) begin errors++; $display("FAIL reset_burst_flags: got %b expected 00", {burst_active, burst_err}); end
        reset = 1'b0;
    endtask

    task automatic test_b_write();
        do_reset();
        b_req = 1; b_wren = 1; b_addr = 9'h03F; b_wdata = 32'h12345678; b_be = 4'b0011;
        tick();
        b_req = 0;
        checks++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin errors++; $display("FAIL bwr_gnt: got a=%b b=%b expected a=0 b=1", a_gnt, b_gnt); end
        checks++; if ({ram_wren, ram_be} !== 5'b1_0011) begin errors++; $display("FAIL bwr_wren_be: got %b expected 10011", {ram_wren, ram_be}); end
        checks++; if (ram_addr !== 9'h03F || ram_wdata !== 32'h12345678) begin errors++; $display("FAIL bwr_addr_data: got %h/%h expected 03f/12345678", ram_addr, ram_wdata); end
        tick();
        checks++; if ({ram_wren, ram_be, b_gnt, b_rvalid} !== 7'b0) begin errors++; $display("FAIL bwr_one_cycle: got %b expected 0000000", {ram_wren, ram_be, b_gnt, b_rvalid}); end
    endtask

    task automatic test_single_read();
        do_reset();
        b_req = 1; b_wren = 1; b_addr = 9'h005; b_wdata = 32'hDEADBEEF; b_be = 4'hF;
        tick();
        b_req = 0;
        tick();
        a_req = 1; a_wren = 0; a_burst = 0; a_addr = 9'h005;
        tick();
        a_req = 0;
        checks++; if (a_gnt !== 1'b1 || ram_addr !== 9'h005 || ram_wren !== 1'b0 || ram_be !== 4'hF) begin errors++; $display("FAIL ard_cmd: got gnt=%b addr=%h wren=%b be=%h expected 1/005/0/f", a_gnt, ram_addr, ram_wren, ram_be); end
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL ard_early_rvalid: got %b expected 0", a_rvalid); end
        tick();
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ard_data: got v=%b d=%h expected 1/deadbeef", a_rvalid, a_rdata); end
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL ard_b_rvalid: got %b expected 0", b_rvalid); end
        tick();
        checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ard_hold: got v=%b d=%h expected 0/deadbeef", a_rvalid, a_rdata); end
    endtask

    task automatic test_alternate();
        do_reset();
        a_req = 1; b_req = 1; a_wren = 0; b_wren = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 != 0)) begin
                errors++; $display("FAIL alternate[%0d]: got a=%b b=%b expected a=%b b=%b", i, a_gnt, b_gnt, i % 2 == 0, i % 2 != 0);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_burst();
        int beat = 0;
        int c15 = -1;
        bit done = 0;
        logic [8:0] exp_addr;
        do_reset();
        a_req = 1; a_burst = 1; a_wren = 1; a_addr = 9'h1F8; a_wdata = 32'hA000_0000;
        for (int c = 0; c < 80 && !done; c++) begin
            tick();
            if (a_gnt) begin
                exp_addr = 9'h1F8 + 9'(beat);
                checks++;
                if (ram_addr !== exp_addr || ram_be !== 4'hF || ram_wren !== 1'b1 || ram_wdata !== 32'hA000_0000 + 32'(beat) || burst_active !== 1'b1) begin
                    errors++; $display("FAIL burst_beat[%0d]: got addr=%h be=%h wren=%b wd=%h act=%b expected %h/f/1/%h/1", beat, ram_addr, ram_be, ram_wren, ram_wdata, burst_active, exp_addr, 32'hA000_0000 + 32'(beat));
                end
                beat++;
                a_wren = 0;
                a_addr = 9'($urandom);
                a_wdata = 32'hA000_0000 + 32'(beat);
                if (beat == 2) begin b_req = 1; b_wren = 0; b_addr = 9'h011; end
                if (beat == 16) begin a_req = 0; a_burst = 0; c15 = c; end
            end
            if (b_gnt) begin
                checks++;
                if (beat != 16 || c != c15 + 1 || burst_active !== 1'b0) begin
                    errors++; $display("FAIL burst_b_after: got beat=%0d cycle=%0d act=%b expected beat=16 cycle=%0d act=0", beat, c, burst_active, c15 + 1);
                end
                done = 1;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL burst_b_timeout: got no b_gnt after %0d beats expected b_gnt", beat); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_burst_timeout();
        int beats = 0;
        int err_at = -1;
        int bg_at = -1;
        do_reset();
        a_req = 1; a_burst = 1; a_wren = 0; a_addr = 9'h010;
        for (int c = 0; c < 20 && beats < 4; c++) begin
            tick();
            if (a_gnt) beats++;
        end
        a_req = 0; a_burst = 0;
        b_req = 1; b_wren = 0; b_addr = 9'h020;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (burst_err === 1'b1 && err_at < 0) err_at = t;
            if (b_gnt === 1'b1 && bg_at < 0) begin bg_at = t; b_req = 0; end
        end
`ifdef PIF_RAM_ARB_BURST_TIMEOUT_EN
        checks++; if (err_at != 64) begin errors++; $display("FAIL timeout_err: got cycle %0d expected 64", err_at); end
        checks++; if (bg_at != 65) begin errors++; $display("FAIL timeout_b_gnt: got cycle %0d expected 65", bg_at); end
        checks++; if (burst_err !== 1'b1 || burst_active !== 1'b0) begin errors++; $display("FAIL timeout_sticky: got err=%b act=%b expected 1/0", burst_err, burst_active); end
`else
        checks++; if (err_at != -1) begin errors++; $display("FAIL timeout_err: got cycle %0d expected none", err_at); end
        checks++; if (bg_at != -1) begin errors++; $display("FAIL timeout_b_gnt: got cycle %0d expected none", bg_at); end
        checks++; if (burst_active !== 1'b1) begin errors++; $display("FAIL timeout_hold: got act=%b expected 1", burst_active); end
`endif
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        int beats = 0;
        do_reset();
        a_req = 1; a_burst = 1; a_wren = 0; a_addr = 9'h100;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            tick();
            if (a_gnt) beats++;
        end
        checks++; if (beats != 8 || ram_addr !== 9'h107 || ram_wren !== 1'b0) begin errors++; $display("FAIL rst_burst_beat7: got beats=%0d addr=%h wren=%b expected 8/107/0", beats, ram_addr, ram_wren); end
        reset = 1'b1;
        tick();
        checks++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wren, ram_be, burst_active, burst_err} !== 10'b0) begin errors++; $display("FAIL rst_burst_ctrl: got %b expected 0", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wren, ram_be, burst_active, burst_err}); end
        checks++; if (ram_addr !== 9'd0 || ram_wdata !== 32'd0 || a_rdata !== 32'd0) begin errors++; $display("FAIL rst_burst_data: got %h/%h/%h expected 0/0/0", ram_addr, ram_wdata, a_rdata); end
        reset = 1'b0;
        clear_inputs();
        tick();
    endtask

    // Randomized traffic against a transaction-level model of the arbitration rules
    task automatic test_random();
        logic [31:0] ref_mem [512];
        bit m_last_a = 0, m_pa = 0, m_pb = 0, m_burst = 0, m_err = 0;
        int m_beat = 0, m_idle = 0;
        int m_base = 0;
        bit m_bwren = 0;
        bit ea, eb, e_wren, e_act, e_ard, e_brd, p_ard = 0, p_brd = 0;
        logic [3:0]  e_be;
        int e_addr;
        logic [31:0] e_wdata, e_rd, p_rd = '0, exp_ardata = '0, exp_brdata = '0;
        do_reset();
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'(i) * 32'h9E3779B1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            a_req = ($urandom_range(0, 3) != 0);
            a_burst = ($urandom_range(0, 11) == 0);
            a_wren = $urandom_range(0, 1) == 1;
            a_addr = 9'($urandom);
            a_wdata = $urandom;
            b_req = ($urandom_range(0, 2) != 0);
            b_wren = $urandom_range(0, 1) == 1;
            b_addr = 9'($urandom);
            b_wdata = $urandom;
            b_be = 4'($urandom);
            ea = 0; eb = 0; e_wren = 0; e_be = 4'h0; e_addr = 0; e_wdata = '0; e_act = 0;
            if (m_burst) begin
                if (a_req && !m_pa) begin
                    ea = 1; e_addr = (m_base + m_beat) % 512; e_wren = m_bwren; e_be = 4'hF; e_wdata = a_wdata;
                    m_beat++; m_idle = 0; e_act = 1;
                    if (m_beat == 16) begin m_burst = 0; m_last_a = 1; end
                end else begin
                    m_idle++;
`ifdef PIF_RAM_ARB_BURST_TIMEOUT_EN
                    if (m_idle == 64) begin m_burst = 0; m_err = 1; m_last_a = 1; end
`endif
                end
            end else if (a_req && !m_pa && (!(b_req && !m_pb) || !m_last_a)) begin
                ea = 1; e_addr = int'(a_addr); e_wren = a_wren; e_be = 4'hF; e_wdata = a_wdata; m_last_a = 1;
                if (a_burst) begin m_burst = 1; m_base = int'(a_addr); m_beat = 1; m_bwren = a_wren; m_idle = 0; end
            end else if (b_req && !m_pb) begin
                eb = 1; e_addr = int'(b_addr); e_wren = b_wren; e_be = b_be; e_wdata = b_wdata; m_last_a = 0;
            end
            e_act = e_act | m_burst;
            m_pa = ea; m_pb = eb;
            e_ard = ea && !e_wren;
            e_brd = eb && !e_wren;
            e_rd = ref_mem[e_addr];
            if (e_wren)
                for (int k = 0; k < 4; k++) if (e_be[k]) ref_mem[e_addr][8*k +: 8] = e_wdata[8*k +: 8];
            tick();
            checks++;
            if (a_gnt !== ea || b_gnt !== eb || ram_wren !== e_wren || ram_be !== e_be) begin
                errors++; $display("FAIL rnd_cmd[%0d]: got a=%b b=%b wren=%b be=%h expected a=%b b=%b wren=%b be=%h", cyc, a_gnt, b_gnt, ram_wren, ram_be, ea, eb, e_wren, e_be);
            end
            if (ea || eb) begin
                checks++;
                if (ram_addr !== 9'(e_addr) || (e_wren && ram_wdata !== e_wdata)) begin
                    errors++; $display("FAIL rnd_addr[%0d]: got addr=%h wd=%h expected addr=%h wd=%h", cyc, ram_addr, ram_wdata, 9'(e_addr), e_wdata);
                end
            end
            checks++;
            if (burst_active !== e_act || burst_err !== m_err) begin
                errors++; $display("FAIL rnd_flags[%0d]: got act=%b err=%b expected act=%b err=%b", cyc, burst_active, burst_err, e_act, m_err);
            end
            if (p_ard) exp_ardata = p_rd;
            if (p_brd) exp_brdata = p_rd;
            checks++;
            if (a_rvalid !== p_ard || b_rvalid !== p_brd || a_rdata !== exp_ardata || b_rdata !== exp_brdata) begin
                errors++; $display("FAIL rnd_rdata[%0d]: got av=%b ad=%h bv=%b bd=%h expected av=%b ad=%h bv=%b bd=%h", cyc, a_rvalid, a_rdata, b_rvalid, b_rdata, p_ard, exp_ardata, p_brd, exp_brdata);
            end
            p_ard = e_ard; p_brd = e_brd; p_rd = e_rd;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_b_write();
        test_single_read();
        test_alternate();
        test_burst();
        test_burst_timeout();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
